// File: rtl/axis_input_dma_sequencer.sv
// axis_input_dma_sequencer: per-layer weights + pixels_1/pixels_2 read command sequencer.
// Define INPUT_SEQ_PERF_EN to add the perf_cycles layer cycle counter output.
module axis_input_dma_sequencer #(
  parameter int COPIES          = 2,
  parameter int ADDR_WIDTH      = 32,
  parameter int BTT_WIDTH       = 23,
  parameter int BLOCKS_WIDTH    = 10,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic                    s_desc_tvalid,
  output logic                    s_desc_tready,
  input  logic [ADDR_WIDTH-1:0]   s_desc_w_addr,
  input  logic [BTT_WIDTH-1:0]    s_desc_w_btt,
  input  logic [ADDR_WIDTH-1:0]   s_desc_p_addr,
  input  logic [ADDR_WIDTH-1:0]   s_desc_p2_offset,
  input  logic [ADDR_WIDTH-1:0]   s_desc_p_stride,
  input  logic [BTT_WIDTH-1:0]    s_desc_p_btt,
  input  logic [BLOCKS_WIDTH-1:0] s_desc_blocks_m1,
  output logic                    m_cmd_w_tvalid,
  input  logic                    m_cmd_w_tready,
  output logic [ADDR_WIDTH-1:0]   m_cmd_w_addr,
  output logic [BTT_WIDTH-1:0]    m_cmd_w_btt,
  output logic                    m_cmd_w_eof,
  output logic                    m_cmd_p1_tvalid,
  input  logic                    m_cmd_p1_tready,
  output logic [ADDR_WIDTH-1:0]   m_cmd_p1_addr,
  output logic [BTT_WIDTH-1:0]    m_cmd_p1_btt,
  output logic                    m_cmd_p1_eof,
  output logic                    m_cmd_p2_tvalid,
  input  logic                    m_cmd_p2_tready,
  output logic [ADDR_WIDTH-1:0]   m_cmd_p2_addr,
  output logic [BTT_WIDTH-1:0]    m_cmd_p2_btt,
  output logic                    m_cmd_p2_eof,
  input  logic                    sts_w_done,
  input  logic                    sts_p1_done,
  input  logic                    sts_p2_done,
  input  logic                    sts_err,
  output logic                    layer_done,
  output logic                    busy,
  output logic                    err
`ifdef INPUT_SEQ_PERF_EN
  ,
  output logic [31:0]             perf_cycles
`endif
);
  localparam int CW = BLOCKS_WIDTH + 1;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE_W, S_ISSUE_P, S_WAIT} state_t;
  state_t r_state, w_next;
  logic [ADDR_WIDTH-1:0]   r_w_addr, r_p_addr, r_p2_off, r_stride;
  logic [BTT_WIDTH-1:0]    r_w_btt, r_p_btt;
  logic [BLOCKS_WIDTH-1:0] r_blocks_m1, r_blk;
  logic [CW-1:0]           r_p1_cnt, r_p2_cnt, r_cmpl;
  logic [4:0]              r_out;
  logic                    r_p1_acc, r_p2_acc, r_w_seen, r_err;
  logic w_accept, w_p_en, w_p1_hs, w_p2_hs, w_issue, w_cmpl, w_fin;
  assign w_accept        = s_desc_tvalid && s_desc_tready;
  assign w_p_en          = r_state == S_ISSUE_P && r_out < 5'(MAX_OUTSTANDING);
  assign s_desc_tready   = r_state == S_IDLE;
  assign busy            = r_state != S_IDLE;
  assign err             = r_err;
  assign m_cmd_w_tvalid  = r_state == S_ISSUE_W;
  assign m_cmd_p1_tvalid = w_p_en && !r_p1_acc;
  assign m_cmd_p2_tvalid = COPIES > 1 && w_p_en && !r_p2_acc;
  assign m_cmd_w_addr    = r_w_addr;
  assign m_cmd_p1_addr   = r_p_addr;
  assign m_cmd_p2_addr   = r_p_addr + r_p2_off;
  assign m_cmd_w_btt     = r_w_btt;
  assign m_cmd_p1_btt    = r_p_btt;
  assign m_cmd_p2_btt    = r_p_btt;
  assign m_cmd_w_eof     = 1'b1;
  assign m_cmd_p1_eof    = 1'b1;
  assign m_cmd_p2_eof    = 1'b1;
  assign w_p1_hs = m_cmd_p1_tvalid && m_cmd_p1_tready;
  assign w_p2_hs = m_cmd_p2_tvalid && m_cmd_p2_tready;
  assign w_issue = w_p_en && (r_p1_acc || w_p1_hs) && (COPIES == 1 || r_p2_acc || w_p2_hs);
  // a block is complete once every active copy has reported more dones than blocks already retired
  assign w_cmpl  = r_p1_cnt > r_cmpl && (COPIES == 1 || r_p2_cnt > r_cmpl);
  assign w_fin   = r_w_seen && r_cmpl == {1'b0, r_blocks_m1} + CW'(1);
  assign layer_done = r_state == S_WAIT && w_fin && !sts_err;

  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) r_state <= S_IDLE;
    else r_state <= w_next;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    w_next = w_accept ? S_ISSUE_W : S_IDLE;
      S_ISSUE_W: w_next = m_cmd_w_tready ? S_ISSUE_P : S_ISSUE_W;
      S_ISSUE_P: w_next = (w_issue && r_blk == r_blocks_m1) ? S_WAIT : S_ISSUE_P;
      S_WAIT:    w_next = w_fin ? S_IDLE : S_WAIT;
      default:   w_next = S_IDLE;
    endcase
    if (sts_err) w_next = S_IDLE;
  end

  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      r_w_addr <= '0; r_w_btt <= '0; r_p_addr <= '0; r_p2_off <= '0; r_stride <= '0; r_p_btt <= '0;
      r_blocks_m1 <= '0; r_blk <= '0; r_p1_cnt <= '0; r_p2_cnt <= '0; r_cmpl <= '0; r_out <= '0;
      r_p1_acc <= 1'b0; r_p2_acc <= 1'b0; r_w_seen <= 1'b0; r_err <= 1'b0;
    end else if (w_accept) begin
      r_w_addr <= s_desc_w_addr; r_w_btt <= s_desc_w_btt; r_p_addr <= s_desc_p_addr;
      r_p2_off <= s_desc_p2_offset; r_stride <= s_desc_p_stride; r_p_btt <= s_desc_p_btt;
      r_blocks_m1 <= s_desc_blocks_m1; r_blk <= '0; r_p1_cnt <= '0; r_p2_cnt <= '0; r_cmpl <= '0;
      r_out <= '0; r_p1_acc <= 1'b0; r_p2_acc <= 1'b0; r_w_seen <= 1'b0; r_err <= sts_err;
    end else begin
      if (sts_err) r_err <= 1'b1;
      if (busy) begin
        r_p1_cnt <= r_p1_cnt + CW'(sts_p1_done);
        r_p2_cnt <= r_p2_cnt + CW'(sts_p2_done);
        r_w_seen <= r_w_seen || sts_w_done;
        r_cmpl   <= r_cmpl + CW'(w_cmpl);
        r_out    <= r_out + 5'(w_issue) - 5'(w_cmpl);
        r_p1_acc <= !w_issue && (r_p1_acc || w_p1_hs);
        r_p2_acc <= !w_issue && (r_p2_acc || w_p2_hs);
        if (w_issue) begin
          r_blk    <= r_blk + BLOCKS_WIDTH'(1);
          r_p_addr <= r_p_addr + r_stride;
        end
      end
    end

`ifdef INPUT_SEQ_PERF_EN
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) perf_cycles <= '0;
    else if (w_accept) perf_cycles <= 32'd1;
    else if (busy && perf_cycles != '1) perf_cycles <= perf_cycles + 32'd1;
`endif
endmodule

// File: tb/tb_axis_input_dma_sequencer.sv
// tb_axis_input_dma_sequencer: directed stimulus with an address/count model checking every handshake.
module tb_axis_input_dma_sequencer;
  logic aclk = 1'b0, aresetn = 1'b1;
  always #5 aclk = ~aclk;
  logic d_valid = 0, d_ready;
  logic [31:0] f_w_addr = 0, f_p_addr = 0, f_off = 0, f_stride = 0;
  logic [22:0] f_w_btt = 0, f_p_btt = 0;
  logic [9:0]  f_bm1 = 0;
  logic w_v, p1_v, p2_v, w_e, p1_e, p2_e, w_r = 0, p1_r = 0, p2_r = 0;
  logic [31:0] w_a, p1_a, p2_a;
  logic [22:0] w_b, p1_b, p2_b;
  logic s_w = 0, s_1 = 0, s_2 = 0, s_e = 0, ld, bsy, er;
  logic c_dv = 0, c_dr, c_wv, c_we, c_p1v, c_p1e, c_p2v, c_p2e, c_sw = 0, c_s1 = 0, c_ld, c_busy, c_err;
  logic c_one = 1, c_zero = 0;
  logic [31:0] c_wa, c_p1a, c_p2a;
  logic [22:0] c_wb, c_p1b, c_p2b;
  int checks = 0, errors = 0;

  axis_input_dma_sequencer dut (
    .aclk(aclk), .aresetn(aresetn), .s_desc_tvalid(d_valid), .s_desc_tready(d_ready),
    .s_desc_w_addr(f_w_addr), .s_desc_w_btt(f_w_btt), .s_desc_p_addr(f_p_addr),
    .s_desc_p2_offset(f_off), .s_desc_p_stride(f_stride), .s_desc_p_btt(f_p_btt), .s_desc_blocks_m1(f_bm1),
    .m_cmd_w_tvalid(w_v), .m_cmd_w_tready(w_r), .m_cmd_w_addr(w_a), .m_cmd_w_btt(w_b), .m_cmd_w_eof(w_e),
    .m_cmd_p1_tvalid(p1_v), .m_cmd_p1_tready(p1_r), .m_cmd_p1_addr(p1_a), .m_cmd_p1_btt(p1_b), .m_cmd_p1_eof(p1_e),
    .m_cmd_p2_tvalid(p2_v), .m_cmd_p2_tready(p2_r), .m_cmd_p2_addr(p2_a), .m_cmd_p2_btt(p2_b), .m_cmd_p2_eof(p2_e),
    .sts_w_done(s_w), .sts_p1_done(s_1), .sts_p2_done(s_2), .sts_err(s_e),
    .layer_done(ld), .busy(bsy), .err(er));

  axis_input_dma_sequencer #(.COPIES(1)) dut1 (
    .aclk(aclk), .aresetn(aresetn), .s_desc_tvalid(c_dv), .s_desc_tready(c_dr),
    .s_desc_w_addr(f_w_addr), .s_desc_w_btt(f_w_btt), .s_desc_p_addr(f_p_addr),
    .s_desc_p2_offset(f_off), .s_desc_p_stride(f_stride), .s_desc_p_btt(f_p_btt), .s_desc_blocks_m1(f_bm1),
    .m_cmd_w_tvalid(c_wv), .m_cmd_w_tready(c_one), .m_cmd_w_addr(c_wa), .m_cmd_w_btt(c_wb), .m_cmd_w_eof(c_we),
    .m_cmd_p1_tvalid(c_p1v), .m_cmd_p1_tready(c_one), .m_cmd_p1_addr(c_p1a), .m_cmd_p1_btt(c_p1b), .m_cmd_p1_eof(c_p1e),
    .m_cmd_p2_tvalid(c_p2v), .m_cmd_p2_tready(c_one), .m_cmd_p2_addr(c_p2a), .m_cmd_p2_btt(c_p2b), .m_cmd_p2_eof(c_p2e),
    .sts_w_done(c_sw), .sts_p1_done(c_s1), .sts_p2_done(c_zero), .sts_err(c_zero),
    .layer_done(c_ld), .busy(c_busy), .err(c_err));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Model: one layer's commands follow from the latched descriptor by plain arithmetic.
  logic [31:0] m_w_addr, m_p_addr, m_off, m_stride;
  logic [22:0] m_w_btt, m_p_btt;
  int m_blocks, n_w, n_p1, n_p2, n_dw, n_d1, n_d2;
  bit m_abort = 1;
  logic pv_1, pr_1, pv_2, pr_2, pv_w, pr_w, p_err;
  logic [31:0] pa_1, pa_2;

  always @(negedge aclk) begin : cmp
    logic [31:0] e;
    int dmin;
    if (!aresetn) begin
      n_w = 0; n_p1 = 0; n_p2 = 0; n_dw = 0; n_d1 = 0; n_d2 = 0; m_abort = 1;
      pv_1 = 0; pv_2 = 0; pv_w = 0; p_err = 0;
    end else begin
      dmin = n_d1 < n_d2 ? n_d1 : n_d2;
      if (d_valid && d_ready) begin
        m_w_addr = f_w_addr; m_w_btt = f_w_btt; m_p_addr = f_p_addr; m_off = f_off;
        m_stride = f_stride; m_p_btt = f_p_btt; m_blocks = int'(f_bm1) + 1;
        n_w = 0; n_p1 = 0; n_p2 = 0; n_dw = 0; n_d1 = 0; n_d2 = 0; m_abort = 0;
      end else begin
        if (pv_w && !pr_w && !p_err) chk("w_hold", w_v, 1);
        if (pv_1 && !pr_1 && !p_err) chk("p1_hold", {p1_v, p1_a}, {1'b1, pa_1});
        if (pv_2 && !pr_2 && !p_err) chk("p2_hold", {p2_v, p2_a}, {1'b1, pa_2});
        if (w_v && w_r) begin
          chk("w_once", n_w, 0);
          chk("w_cmd", {w_e, w_a, 9'd0, w_b}, {1'b1, m_w_addr, 9'd0, m_w_btt});
          n_w++;
        end
        if (p1_v && p1_r) begin
          e = m_p_addr + m_stride * 32'(n_p1);
          chk("p1_cmd", {p1_e, p1_a, 9'd0, p1_b}, {1'b1, e, 9'd0, m_p_btt});
          chk("p1_order", {n_w == 1, n_p1 < m_blocks, n_p1 - dmin < 2}, 3'b111);
          n_p1++;
        end
        if (p2_v && p2_r) begin
          e = m_p_addr + m_off + m_stride * 32'(n_p2);
          chk("p2_cmd", {p2_e, p2_a, 9'd0, p2_b}, {1'b1, e, 9'd0, m_p_btt});
          chk("p2_order", {n_w == 1, n_p2 < m_blocks, n_p2 - dmin < 2}, 3'b111);
          n_p2++;
        end
        if (ld)
          chk("layer_done_ok", {!m_abort, n_dw > 0, dmin >= m_blocks, n_p1 == m_blocks, n_p2 == m_blocks}, 5'h1f);
        n_dw += int'(s_w); n_d1 += int'(s_1); n_d2 += int'(s_2);
        if (s_e) m_abort = 1;
      end
      pv_w = w_v; pr_w = w_r; pv_1 = p1_v; pr_1 = p1_r; pa_1 = p1_a;
      pv_2 = p2_v; pr_2 = p2_r; pa_2 = p2_a; p_err = s_e;
    end
  end

  bit c_p2_seen = 0;
  int c_p1_hs = 0;
  logic [31:0] c_p1_addr = 0;
  always @(negedge aclk)
    if (aresetn) begin
      if (c_p2v) c_p2_seen = 1;
      if (c_p1v) begin c_p1_hs++; c_p1_addr = c_p1a; end
    end

  task automatic tick; @(posedge aclk); #1; endtask

  task automatic send(input logic [31:0] wa, input logic [22:0] wb, input logic [31:0] pa, input logic [31:0] po,
                      input logic [31:0] ps, input logic [22:0] pb, input logic [9:0] bm);
    f_w_addr = wa; f_w_btt = wb; f_p_addr = pa; f_off = po; f_stride = ps; f_p_btt = pb; f_bm1 = bm;
    d_valid = 1; tick; d_valid = 0;
  endtask

  task automatic pulse(input logic w, input logic p1, input logic p2, input logic e);
    s_w = w; s_1 = p1; s_2 = p2; s_e = e; tick; s_w = 0; s_1 = 0; s_2 = 0; s_e = 0;
  endtask

  task automatic wait_ld(input string name, input int max);
    bit seen = 0;
    for (int i = 0; i < max && !seen; i++) begin @(negedge aclk); if (ld) seen = 1; end
    chk(name, seen, 1);
    tick;
  endtask

  initial begin
    #3 aresetn = 0;
    tick;
    chk("rst_flags", {w_v, p1_v, p2_v, ld, bsy, er, d_ready}, 7'b0000001);
    chk("rst_addr", {w_a, p2_a}, 64'd0);
    chk("rst_btt", {p1_a, 9'd0, w_b}, 64'd0);
    tick; aresetn = 1; tick;
    // T1: full layer, all movers ready
    w_r = 1; p1_r = 1; p2_r = 1;
    send(32'h1000, 23'h400, 32'h8000, 32'h100, 32'h200, 23'h100, 10'd2);
    chk("t1_w_latency", {w_v, w_a}, {1'b1, 32'h1000});
    tick;
    chk("t1_first_pair", {p1_v, p2_v, p1_a, p2_a}, {2'b11, 32'h8000, 32'h8100});
    tick;
    chk("t1_second_p1", p1_a, 32'h8200);
    tick;
    chk("t1_cap_stall", {p1_v, p2_v, p1_a}, {2'b00, 32'h8400});
    pulse(1, 1, 1, 0); tick; tick;
    pulse(0, 1, 1, 0); tick;
    pulse(0, 1, 1, 0);
    wait_ld("t1_layer_done", 20);
    chk("t1_counts", {8'(n_w), 8'(n_p1), 8'(n_p2)}, {8'd1, 8'd3, 8'd3});
    chk("t1_idle", {d_ready, bsy}, 2'b10);
    // T2: no dones -> exactly two pairs in flight
    send(32'h1000, 23'h400, 32'h8000, 32'h100, 32'h200, 23'h100, 10'd2);
    repeat (10) tick;
    chk("t2_stall_pairs", {8'(n_p1), 8'(n_p2), 1'b0, p1_v}, {8'd2, 8'd2, 2'b00});
    pulse(0, 1, 1, 0);
    repeat (4) tick;
    chk("t2_third_pair", {8'(n_p1), 8'(n_p2)}, {8'd3, 8'd3});
    pulse(1, 1, 1, 0); pulse(0, 1, 1, 0);
    wait_ld("t2_layer_done", 20);
    // T3: p2 back-pressure, wrapping p2 address
    p2_r = 0;
    send(32'h2000, 23'h40, 32'hFFFF_FF00, 32'h180, 32'h100, 23'h20, 10'd3);
    tick; tick;
    repeat (5) tick;
    chk("t3_p1_single", {8'(n_p1), 8'(n_p2), 1'b0, p1_v}, {8'd1, 8'd0, 2'b00});
    chk("t3_p2_held", {p2_v, p2_a, 9'd0, p2_b}, {1'b1, 32'h0000_0080, 9'd0, 23'h20});
    // T5: mover error aborts the layer
    pulse(0, 0, 0, 1);
    chk("t5_abort", {er, bsy, w_v, p1_v, p2_v, d_ready}, 6'b100001);
    repeat (3) tick;
    chk("t5_err_sticky", {er, ld}, 2'b10);
    // T6: new descriptor clears err, then async reset mid-WAIT
    p2_r = 1;
    send(32'h3000, 23'h10, 32'h4000, 32'h8, 32'h10, 23'h8, 10'd0);
    chk("t6_err_clear", {er, bsy}, 2'b01);
    repeat (3) tick;
    chk("t6_in_wait", {bsy, p1_v, p2_v, 8'(n_p1)}, {3'b100, 8'd1});
    #2 aresetn = 0;
    #1 chk("t6_async_rst", {w_v, p1_v, p2_v, ld, bsy, er, d_ready, p1_a}, {7'b0000001, 32'd0});
    tick; aresetn = 1; tick;
    chk("t6_ready_after", {d_ready, bsy}, 2'b10);
    // T4: single-copy instance, one block
    c_dv = 1; tick; c_dv = 0;
    tick; tick;
    chk("t4_wait", {c_busy, c_p1v, c_p2v}, 3'b100);
    c_sw = 1; c_s1 = 1; tick; c_sw = 0; c_s1 = 0;
    begin
      bit seen = 0;
      for (int i = 0; i < 10 && !seen; i++) begin @(negedge aclk); if (c_ld) seen = 1; end
      chk("t4_layer_done", seen, 1);
    end
    tick;
    chk("t4_p1_only", {7'd0, c_p2_seen, 8'(c_p1_hs), c_p1_addr}, {8'd0, 8'd1, 32'h4000});
    chk("t4_idle", {c_dr, c_busy, c_err}, 3'b100);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1);
  end
endmodule
